// File: rtl/lbp_host_mem_pkg.sv
// lbp_host_mem_pkg: default geometry and phase encoding shared by the LBP host memory
package lbp_host_mem_pkg;
    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_AW = 14;
    localparam int DEF_DW = 8;
    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/lbp_host_mem_sp_ram.sv
// lbp_host_mem_sp_ram: one write port, one registered read port; read data clears on reset
module lbp_host_mem_sp_ram #(
    parameter int DEPTH = 16384,
    parameter int AW = 14,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_q
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= reset ? '0 : mem[raddr];
    end
endmodule

// File: rtl/lbp_host_mem.sv
// lbp_host_mem: loads a gray image, serves tagged gray reads, captures LBP results
// and streams them out once the engine finishes.
module lbp_host_mem
    import lbp_host_mem_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic [AW-1:0] gray_addr,
    input  logic          gray_req,
    output logic          gray_ready,
    output logic [DW-1:0] gray_data,
    input  logic [AW-1:0] lbp_addr,
    input  logic          lbp_valid,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    input  logic          dump_ready,
    output logic          done
);
    localparam logic [AW:0] SIZE = (AW+1)'(IMG_W * IMG_H);
    state_e state_q, state_d;
    logic [AW:0] wp_q, wp_d, dp_q, dp_d;
    logic [AW-1:0] rd_tag_q, rd_tag_d;
    logic load_ready_q, load_ready_d, rd_vld_q, rd_vld_d, oob_q, oob_d;
    logic dump_valid_q, dump_valid_d, done_q, done_d;
    logic load_hs, dump_hs, lbp_we;
    logic [AW-1:0] lbp_waddr;
    logic [DW-1:0] lbp_wdata, gray_q, lbp_q;

    always_comb begin
        load_hs = load_valid && load_ready_q;
        dump_hs = dump_valid_q && dump_ready;
        wp_d = wp_q + (AW+1)'(load_hs);
        dp_d = dp_q + (AW+1)'(dump_hs);
        case (state_q)
            ST_LOAD:  state_d = (wp_d == SIZE) ? ST_SERVE : ST_LOAD;
            ST_SERVE: state_d = finish ? ST_DUMP : ST_SERVE;
            ST_DUMP:  state_d = (dp_d == SIZE) ? ST_DONE : ST_DUMP;
            default:  state_d = ST_DONE;
        endcase
        load_ready_d = (state_q == ST_LOAD) && (wp_d != SIZE);
        rd_vld_d = state_q == ST_SERVE;
        rd_tag_d = gray_addr;
        oob_d = {1'b0, gray_addr} >= SIZE;
        // dump pointer prefetch: RAM always reads the address that will be presented next cycle
        dump_valid_d = (state_q == ST_DUMP) && (dp_d != SIZE);
        done_d = done_q || ((state_q == ST_DUMP) && (dp_d == SIZE));
        // loading zeroes the result RAM so border pixels the engine never writes dump as 0
        lbp_we = load_hs || ((state_q == ST_SERVE) && lbp_valid);
        lbp_waddr = load_hs ? wp_q[AW-1:0] : lbp_addr;
        lbp_wdata = load_hs ? '0 : lbp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            wp_q <= '0;
            dp_q <= '0;
            rd_tag_q <= '0;
            load_ready_q <= 1'b0;
            rd_vld_q <= 1'b0;
            oob_q <= 1'b0;
            dump_valid_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q <= wp_d;
            dp_q <= dp_d;
            rd_tag_q <= rd_tag_d;
            load_ready_q <= load_ready_d;
            rd_vld_q <= rd_vld_d;
            oob_q <= oob_d;
            dump_valid_q <= dump_valid_d;
            done_q <= done_d;
        end
    end

    lbp_host_mem_sp_ram #(.DEPTH(IMG_W * IMG_H), .AW(AW), .DW(DW)) gray_mem (
        .clk(clk), .reset(reset), .we(load_hs), .waddr(wp_q[AW-1:0]), .wdata(load_data),
        .raddr(gray_addr), .rdata_q(gray_q)
    );

    lbp_host_mem_sp_ram #(.DEPTH(IMG_W * IMG_H), .AW(AW), .DW(DW)) lbp_mem (
        .clk(clk), .reset(reset), .we(lbp_we), .waddr(lbp_waddr), .wdata(lbp_wdata),
        .raddr(dp_d[AW-1:0]), .rdata_q(lbp_q)
    );

    assign load_ready = load_ready_q;
    assign gray_ready = gray_req && rd_vld_q && (state_q == ST_SERVE) && (rd_tag_q == gray_addr);
    assign gray_data = oob_q ? '0 : gray_q;
    assign dump_valid = dump_valid_q;
    assign dump_addr = dump_valid_q ? dp_q[AW-1:0] : '0;
    assign dump_data = dump_valid_q ? lbp_q : '0;
    assign done = done_q;
endmodule
